alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//   Parametrised, handshaked sequential ALU; successor to the fixed 8-bit ALU.
//   Executes the 20-op set (arith, logic, shifts, rotates) on WIDTH-bit operands, registers result + flags.
//   Sits between the operand-fetch stage (valid/ready in) and writeback (valid/ready out); one op in flight.
// PARAMETERS
//   WIDTH    8                 operand/result width, >=4
//   SHAMT_W  $clog2(WIDTH)     shift-count width, taken from operand_b[SHAMT_W-1:0]
// PORTS
//   clk         in   1        clock, rising edge
//   rst_n       in   1        reset, asynchronous, active-low
//   in_valid    in   1        request valid
//   in_ready    out  1        request accepted when in_valid & in_ready
//   opcode      in   5        operation (encodings in alu_pkg, 0..19)
//   operand_a   in   WIDTH    operand A
//   operand_b   in   WIDTH    operand B / shift count
//   carry_in    in   1        carry for CADD, L_CROT, R_CROT
//   borrow_in   in   1        borrow for BSUB
//   out_valid   out  1        result valid
//   out_ready   in   1        result consumed when out_valid & out_ready
//   y_out       out  WIDTH    result
//   carry_out   out  1        add carry / last bit shifted-rotated out
//   borrow_out  out  1        unsigned borrow for SUB/BSUB/DEC
//   zero, negative, overflow, parity  out 1 each: y==0, y[W-1], signed ovf, ^y
//   illegal_op  out  1        opcode >19
// BEHAVIOUR
//   - Reset: state IDLE; all outputs, operand/count regs 0; in_ready=rst_n & (state==IDLE).
//   - FSM IDLE -accept-> EXEC; EXEC -(count==0)-> DONE; DONE -(out_valid&out_ready)-> IDLE.
//   - Accept captures opcode, operands, carry_in, borrow_in; inputs ignored outside IDLE.
//   - Non-shift ops: one EXEC cycle; out_valid rises 1 cycle after accept edge.
//   - Shift/rotate: count n=operand_b[SHAMT_W-1:0]; one bit per EXEC cycle; latency max(1,n).
//   - DONE: y_out/flags held stable while out_valid & !out_ready; in_ready=0; no overlap.
//   - Arith mod 2^WIDTH: ADD {c,y}=A+B; CADD +carry_in; SUB/BSUB y=A-B(-borrow_in), borrow=unsigned underflow;
//     NEG y=-A, ovf iff A==min; INC/DEC +/-1, ovf at max/min, carry on INC wrap, borrow on DEC wrap.
//   - Overflow = signed ovf for ADD/CADD/SUB/BSUB/NEG/INC/DEC; L_ARITH_SHIFT: sign bit changed on any step.
//   - PASS y=A; AND/OR/XOR bitwise; COMP y=~A. Logic ops: carry/borrow/overflow=0.
//   - Shifts: LSL/L_ARITH in 0; LSR in 0; R_ARITH replicates sign; ROL/ROR WIDTH-bit;
//     L_CROT/R_CROT rotate WIDTH+1 bits {carry,y}, seeded with carry_in.
//   - Shift carry_out = last bit out; n==0: y=A, carry_out=0 (CROT: carry_in).
//   - zero/negative/parity from final y for every legal op.
//   - Illegal opcode: 1-cycle EXEC, y=0, all flags 0, illegal_op=1.
//   - rst_n low mid-EXEC/DONE: immediate abort to IDLE, all outputs 0, no result delivered.
//   - Simultaneous out_ready handshake and in_valid in DONE: only the result transfer occurs;
//     new request accepted next cycle in IDLE.
// CONFIGURATION
//   ALU_BARREL_SHIFT_EN defined: shifts/rotates done in a single EXEC cycle by barrel
//     logic; all ops latency 1; results/flags identical to iterative mode.
//   Not defined: iterative 1-bit/cycle shifter as above (smaller area).
// STRUCTURE
//   alu_pkg: opcode localparams (ADD=0..R_CROT=19), state enum {IDLE,EXEC,DONE},
//     is_shift(opcode) function.
//   Sub-module alu_shift_unit: combinational shift/rotate step (1 bit, or n bits under
//     ALU_BARREL_SHIFT_EN), returns {carry, y, sign_changed}.
// TESTING (WIDTH=8)
//   ADD 0x7F+0x01 -> y=0x80, carry=0, ovf=1, neg=1, out_valid 1 cycle after accept.
//   SUB 0x00-0x01 -> y=0xFF, borrow=1, neg=1, parity=0; BSUB 0x05-0x02-1 -> 0x02.
//   R_ARITH_SHIFT 0x80 by 3 -> y=0xF0, carry=0, latency 3 (1 with ALU_BARREL_SHIFT_EN).
//   L_CROT 0x81, carry_in=0, by 1 -> y=0x02, carry=1; shift count 0 -> y=A, latency 1.
//   Hold out_ready=0 for 5 cycles -> y/flags stable, in_ready=0, in_valid pulses ignored.
//   rst_n low mid-shift -> outputs 0 async; after release opcode 25 -> illegal_op=1, y=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM states, op-class helpers.
// Optional build macro: ALU_BARREL_SHIFT_EN (single-cycle barrel shifter instead of 1 bit/cycle).
package alu_pkg;

  localparam int unsigned OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] ADD           = 5'd0;
  localparam logic [OPCODE_W-1:0] CADD          = 5'd1;
  localparam logic [OPCODE_W-1:0] SUB           = 5'd2;
  localparam logic [OPCODE_W-1:0] BSUB          = 5'd3;
  localparam logic [OPCODE_W-1:0] NEG           = 5'd4;
  localparam logic [OPCODE_W-1:0] INC           = 5'd5;
  localparam logic [OPCODE_W-1:0] DEC           = 5'd6;
  localparam logic [OPCODE_W-1:0] PASS          = 5'd7;
  localparam logic [OPCODE_W-1:0] AND           = 5'd8;
  localparam logic [OPCODE_W-1:0] OR            = 5'd9;
  localparam logic [OPCODE_W-1:0] XOR           = 5'd10;
  localparam logic [OPCODE_W-1:0] COMP          = 5'd11;
  localparam logic [OPCODE_W-1:0] LSL           = 5'd12;
  localparam logic [OPCODE_W-1:0] L_ARITH_SHIFT = 5'd13;
  localparam logic [OPCODE_W-1:0] LSR           = 5'd14;
  localparam logic [OPCODE_W-1:0] R_ARITH_SHIFT = 5'd15;
  localparam logic [OPCODE_W-1:0] ROL           = 5'd16;
  localparam logic [OPCODE_W-1:0] ROR           = 5'd17;
  localparam logic [OPCODE_W-1:0] L_CROT        = 5'd18;
  localparam logic [OPCODE_W-1:0] R_CROT        = 5'd19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Shift and rotate ops occupy the contiguous range LSL..R_CROT
  function automatic logic is_shift(input logic [OPCODE_W-1:0] op);
    return (op >= LSL) && (op <= R_CROT);
  endfunction

  // Ops that consume the carry_in input
  function automatic logic uses_carry_in(input logic [OPCODE_W-1:0] op);
    return (op == CADD) || (op == L_CROT) || (op == R_CROT);
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Combinational shift/rotate datapath. Iterative build: one bit step.
// With ALU_BARREL_SHIFT_EN: applies amt steps in one pass.
// Returns the new value, the last bit shifted out (or the carry for CROT) and
// whether the sign bit flipped on any step.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OPCODE_W-1:0]      op,
  input  logic [WIDTH-1:0]         a_in,
  input  logic                     c_in,
`ifdef ALU_BARREL_SHIFT_EN
  input  logic [$clog2(WIDTH)-1:0] amt,
`endif
  output logic [WIDTH-1:0]         y_c,
  output logic                     c_c,
  output logic                     sc_c
);

  // One-bit step; result packed as {carry, value}
  function automatic logic [WIDTH:0] step1(input logic [OPCODE_W-1:0] f_op,
                                           input logic [WIDTH-1:0]    v,
                                           input logic                c);
    logic [WIDTH:0] r;
    case (f_op)
      LSL, L_ARITH_SHIFT: r = {v, 1'b0};
      LSR:                r = {v[0], 1'b0, v[WIDTH-1:1]};
      R_ARITH_SHIFT:      r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      ROL:                r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      ROR:                r = {v[0], v[0], v[WIDTH-1:1]};
      L_CROT:             r = {v, c};
      R_CROT:             r = {v[0], c, v[WIDTH-1:1]};
      default:            r = {c, v};
    endcase
    return r;
  endfunction

  logic [WIDTH:0]   step_r;
  logic [WIDTH-1:0] y_w;
  logic             c_w;
  logic             sc_w;

`ifdef ALU_BARREL_SHIFT_EN
  // Chain amt single-bit steps, accumulating any sign change
  always_comb begin
    step_r = '0;
    y_w    = a_in;
    c_w    = c_in;
    sc_w   = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i < 32'(amt)) begin
        step_r = step1(op, y_w, c_w);
        sc_w   = sc_w | (step_r[WIDTH-1] ^ y_w[WIDTH-1]);
        y_w    = step_r[WIDTH-1:0];
        c_w    = step_r[WIDTH];
      end
    end
  end
`else
  // Single step of the iterative shifter
  always_comb begin
    step_r = step1(op, a_in, c_in);
    y_w    = step_r[WIDTH-1:0];
    c_w    = step_r[WIDTH];
    sc_w   = step_r[WIDTH-1] ^ a_in[WIDTH-1];
  end
`endif

  assign y_c  = y_w;
  assign c_c  = c_w;
  assign sc_c = sc_w;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: accepts one op in IDLE, computes in EXEC
// (shifts one bit per cycle unless ALU_BARREL_SHIFT_EN is defined), and
// holds the registered result and flags in DONE until the consumer takes it.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    operand_a,
  input  logic [WIDTH-1:0]    operand_b,
  input  logic                carry_in,
  input  logic                borrow_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    y_out,
  output logic                carry_out,
  output logic                borrow_out,
  output logic                zero,
  output logic                negative,
  output logic                overflow,
  output logic                parity,
  output logic                illegal_op
);

  localparam int unsigned W1  = WIDTH + 1;
  localparam int unsigned MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};

  state_t                state_q, state_d;
  logic [OPCODE_W-1:0]   op_q, op_d;
  logic [WIDTH-1:0]      a_q, a_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic                  c_q, c_d;
  logic                  bin_q, bin_d;
  logic [SHAMT_W-1:0]    cnt_q, cnt_d;
  logic                  sc_q, sc_d;

  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      y_q, y_d;
  logic                  carry_q, carry_d;
  logic                  borrow_q, borrow_d;
  logic                  zero_q, zero_d;
  logic                  neg_q, neg_d;
  logic                  ovf_q, ovf_d;
  logic                  par_q, par_d;
  logic                  ill_q, ill_d;

  logic [WIDTH-1:0]      sh_y;
  logic                  sh_c;
  logic                  sh_sc;

  logic [W1-1:0]         sum;
  logic [WIDTH-1:0]      fin_y;
  logic                  fin_c, fin_b, fin_v, fin_ill, fin_done;

  alu_shift_unit #(.WIDTH(WIDTH)) u_shift (
    .op   (op_q),
    .a_in (a_q),
    .c_in (c_q),
`ifdef ALU_BARREL_SHIFT_EN
    .amt  (cnt_q),
`endif
    .y_c  (sh_y),
    .c_c  (sh_c),
    .sc_c (sh_sc)
  );

  // Next-state, operand capture, execution and result registration
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    bin_d       = bin_q;
    cnt_d       = cnt_q;
    sc_d        = sc_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    carry_d     = carry_q;
    borrow_d    = borrow_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    par_d       = par_q;
    ill_d       = ill_q;
    sum         = '0;
    fin_y       = '0;
    fin_c       = 1'b0;
    fin_b       = 1'b0;
    fin_v       = 1'b0;
    fin_ill     = 1'b0;
    fin_done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = opcode;
          a_d     = operand_a;
          b_d     = operand_b;
          c_d     = uses_carry_in(opcode) ? carry_in : 1'b0;
          bin_d   = borrow_in;
          cnt_d   = is_shift(opcode) ? operand_b[SHAMT_W-1:0] : '0;
          sc_d    = 1'b0;
          state_d = EXEC;
        end
      end

      EXEC: begin
        fin_done = 1'b1;
        case (op_q)
          ADD: begin
            sum   = {1'b0, a_q} + {1'b0, b_q};
            fin_y = sum[WIDTH-1:0];
            fin_c = sum[WIDTH];
            fin_v = (a_q[MSB] == b_q[MSB]) && (fin_y[MSB] != a_q[MSB]);
          end
          CADD: begin
            sum   = {1'b0, a_q} + {1'b0, b_q} + W1'(c_q);
            fin_y = sum[WIDTH-1:0];
            fin_c = sum[WIDTH];
            fin_v = (a_q[MSB] == b_q[MSB]) && (fin_y[MSB] != a_q[MSB]);
          end
          SUB: begin
            sum   = {1'b0, a_q} - {1'b0, b_q};
            fin_y = sum[WIDTH-1:0];
            fin_b = sum[WIDTH];
            fin_v = (a_q[MSB] != b_q[MSB]) && (fin_y[MSB] != a_q[MSB]);
          end
          BSUB: begin
            sum   = {1'b0, a_q} - {1'b0, b_q} - W1'(bin_q);
            fin_y = sum[WIDTH-1:0];
            fin_b = sum[WIDTH];
            fin_v = (a_q[MSB] != b_q[MSB]) && (fin_y[MSB] != a_q[MSB]);
          end
          NEG: begin
            fin_y = ~a_q + WIDTH'(1);
            fin_v = (a_q == SMIN);
          end
          INC: begin
            sum   = {1'b0, a_q} + W1'(1);
            fin_y = sum[WIDTH-1:0];
            fin_c = sum[WIDTH];
            fin_v = (a_q == SMAX);
          end
          DEC: begin
            sum   = {1'b0, a_q} - W1'(1);
            fin_y = sum[WIDTH-1:0];
            fin_b = sum[WIDTH];
            fin_v = (a_q == SMIN);
          end
          PASS: fin_y = a_q;
          AND:  fin_y = a_q & b_q;
          OR:   fin_y = a_q | b_q;
          XOR:  fin_y = a_q ^ b_q;
          COMP: fin_y = ~a_q;
          LSL, L_ARITH_SHIFT, LSR, R_ARITH_SHIFT, ROL, ROR, L_CROT, R_CROT: begin
`ifdef ALU_BARREL_SHIFT_EN
            fin_y = sh_y;
            fin_c = sh_c;
            fin_v = (op_q == L_ARITH_SHIFT) && sh_sc;
`else
            if (cnt_q == '0) begin
              // Zero shift count: operand passes through untouched
              fin_y = a_q;
              fin_c = c_q;
              fin_v = (op_q == L_ARITH_SHIFT) && sc_q;
            end else begin
              a_d      = sh_y;
              c_d      = sh_c;
              sc_d     = sc_q | sh_sc;
              cnt_d    = cnt_q - SHAMT_W'(1);
              fin_y    = sh_y;
              fin_c    = sh_c;
              fin_v    = (op_q == L_ARITH_SHIFT) && (sc_q | sh_sc);
              fin_done = (cnt_q == SHAMT_W'(1));
            end
`endif
          end
          default: fin_ill = 1'b1;
        endcase

        if (fin_done) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          y_d         = fin_y;
          carry_d     = fin_c;
          borrow_d    = fin_b;
          zero_d      = !fin_ill && (fin_y == '0);
          neg_d       = fin_y[MSB];
          ovf_d       = fin_v;
          par_d       = ^fin_y;
          ill_d       = fin_ill;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      bin_q       <= 1'b0;
      cnt_q       <= '0;
      sc_q        <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      carry_q     <= 1'b0;
      borrow_q    <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      par_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      bin_q       <= bin_d;
      cnt_q       <= cnt_d;
      sc_q        <= sc_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      carry_q     <= carry_d;
      borrow_q    <= borrow_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      par_q       <= par_d;
      ill_q       <= ill_d;
    end
  end

  assign in_ready   = rst_n && (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign y_out      = y_q;
  assign carry_out  = carry_q;
  assign borrow_out = borrow_q;
  assign zero       = zero_q;
  assign negative   = neg_q;
  assign overflow   = ovf_q;
  assign parity     = par_q;
  assign illegal_op = ill_q;

endmodule
